skid_buffer: RTL and testbench



---
 rtl/skid_buffer.sv | 98 +++++++++
 tb/tb_skid_buffer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/skid_buffer.sv
// skid_buffer: single-stage valid/ready pipeline register with one skid entry.
// Every output (data, valid and ready) comes straight from a flop, so no
// combinational path crosses the buffer in either direction. The skid entry
// catches the one beat that upstream launches in the cycle before it sees
// i_ready_o fall. That keeps full throughput without losing any beat.
module skid_buffer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid_i,
  input  logic [DATA_W-1:0] i_data_i,
  output logic              i_ready_o,
  input  logic              e_ready_i,
  output logic              e_valid_o,
  output logic [DATA_W-1:0] e_data_o
);

  // EMPTY: nothing held; BUSY: out_q holds a beat; FULL: out_q and skid_q hold beats
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              e_valid_q, e_valid_d;
  logic              i_ready_q, i_ready_d;

  logic in_xfer;
  logic eg_xfer;

  // Handshakes are judged against the registered flags the neighbours actually see
  assign in_xfer = i_valid_i && i_ready_q;
  assign eg_xfer = e_valid_q && e_ready_i;

  // Next-state and datapath selection; both flags follow the next state, so they stay registered
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_d = ST_BUSY;
          out_d   = i_data_i;
        end
      end
      ST_BUSY: begin
        if (in_xfer && eg_xfer) begin
          out_d = i_data_i;
        end else if (in_xfer) begin
          // The new beat is younger than the one in out_q, so it waits in skid_q
          state_d = ST_FULL;
          skid_d  = i_data_i;
        end else if (eg_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // i_ready_o is low here, so only the drain of the older beat can happen
        if (eg_xfer) begin
          state_d = ST_BUSY;
          out_d   = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    e_valid_d = (state_d != ST_EMPTY);
    i_ready_d = (state_d != ST_FULL);
  end

  // State, payload and flag registers; reset takes priority over any transfer in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      out_q     <= '0;
      skid_q    <= '0;
      e_valid_q <= 1'b0;
      i_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      skid_q    <= skid_d;
      e_valid_q <= e_valid_d;
      i_ready_q <= i_ready_d;
    end
  end

  assign i_ready_o = i_ready_q;
  assign e_valid_o = e_valid_q;
  assign e_data_o  = out_q;

endmodule

// File: tb/tb_skid_buffer.sv
// tb_skid_buffer: directed and random stimulus for skid_buffer, checked against a scoreboard queue.
module tb_skid_buffer;

  localparam int DATA_W = 8;

  logic              clk;
  logic              reset;
  logic              i_valid_i;
  logic [DATA_W-1:0] i_data_i;
  logic              i_ready_o;
  logic              e_ready_i;
  logic              e_valid_o;
  logic [DATA_W-1:0] e_data_o;

  int vectors;
  int miscompares;
  logic [DATA_W-1:0] sb[$];

  skid_buffer #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid_i (i_valid_i),
    .i_data_i  (i_data_i),
    .i_ready_o (i_ready_o),
    .e_ready_i (e_ready_i),
    .e_valid_o (e_valid_o),
    .e_data_o  (e_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge: record the handshakes seen before the edge, update the scoreboard,
  // then check the flags and head data against the scoreboard occupancy.
  task automatic tick();
    logic              rst_now, in_x, eg_x;
    logic [DATA_W-1:0] in_d, eg_d, exp_d;
    rst_now = reset;
    in_x    = i_valid_i && i_ready_o;
    eg_x    = e_valid_o && e_ready_i;
    in_d    = i_data_i;
    eg_d    = e_data_o;
    @(posedge clk);
    #1;
    if (rst_now) begin
      sb.delete();
    end else begin
      if (eg_x) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $error("FAIL egress_unexpected: observed beat %0h expected no beat", eg_d);
        end else begin
          exp_d = sb.pop_front();
          chk("egress_data", 32'(eg_d), 32'(exp_d));
        end
      end
      if (in_x) sb.push_back(in_d);
    end
    chk("e_valid_occ", 32'(e_valid_o), 32'(sb.size() > 0));
    chk("i_ready_occ", 32'(i_ready_o), 32'(sb.size() < 2));
    if (sb.size() > 0) chk("e_data_head", 32'(e_data_o), 32'(sb[0]));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    i_valid_i   = 1'b0;
    i_data_i    = '0;
    e_ready_i   = 1'b0;

    // Reset for two edges with random inputs
    for (int i = 0; i < 2; i++) begin
      i_valid_i = 1'($urandom);
      i_data_i  = 8'($urandom);
      e_ready_i = 1'($urandom);
      tick();
    end
    chk("rst_e_valid", 32'(e_valid_o), 32'd0);
    chk("rst_e_data",  32'(e_data_o),  32'd0);
    chk("rst_i_ready", 32'(i_ready_o), 32'd1);
    reset     = 1'b0;
    i_valid_i = 1'b0;
    e_ready_i = 1'b0;
    tick();
    chk("post_rst_e_valid", 32'(e_valid_o), 32'd0);
    chk("post_rst_e_data",  32'(e_data_o),  32'd0);

    // Fill and stall
    i_valid_i = 1'b1;
    i_data_i  = 8'd90;
    tick();
    chk("fill1_e_valid", 32'(e_valid_o), 32'd1);
    chk("fill1_e_data",  32'(e_data_o),  32'd90);
    chk("fill1_i_ready", 32'(i_ready_o), 32'd1);
    i_data_i = 8'd255;
    tick();
    chk("fill2_i_ready", 32'(i_ready_o), 32'd0);
    chk("fill2_e_data",  32'(e_data_o),  32'd90);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_i_ready", 32'(i_ready_o), 32'd0);
      chk("stall_e_valid", 32'(e_valid_o), 32'd1);
      chk("stall_e_data",  32'(e_data_o),  32'd90);
    end

    // Drain with upstream still offering 255
    e_ready_i = 1'b1;
    tick();
    chk("drain1_e_data",  32'(e_data_o),  32'd255);
    chk("drain1_i_ready", 32'(i_ready_o), 32'd1);
    tick();
    chk("drain2_e_valid", 32'(e_valid_o), 32'd1);
    chk("drain2_e_data",  32'(e_data_o),  32'd255);
    chk("drain2_i_ready", 32'(i_ready_o), 32'd1);
    i_valid_i = 1'b0;
    tick();
    chk("drain3_e_valid", 32'(e_valid_o), 32'd0);
    chk("drain3_e_data_hold", 32'(e_data_o), 32'd255);

    // e_ready_i toggling while empty changes nothing
    for (int i = 0; i < 4; i++) begin
      e_ready_i = ~e_ready_i;
      tick();
      chk("empty_toggle_e_valid", 32'(e_valid_o), 32'd0);
      chk("empty_toggle_e_data",  32'(e_data_o),  32'd255);
    end

    // Streaming 1..100 at full rate
    e_ready_i = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      i_valid_i = 1'b1;
      i_data_i  = 8'(i);
      tick();
      chk("stream_i_ready", 32'(i_ready_o), 32'd1);
      chk("stream_e_data",  32'(e_data_o),  32'(i));
    end
    i_valid_i = 1'b0;
    tick();
    chk("stream_end_e_valid", 32'(e_valid_o), 32'd0);

    // Random traffic and backpressure
    for (int i = 0; i < 10000; i++) begin
      i_valid_i = 1'($urandom);
      i_data_i  = 8'($urandom);
      e_ready_i = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Reset while FULL drops both beats
    e_ready_i = 1'b0;
    i_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_data_i = 8'(8'h10 + i);
      tick();
    end
    chk("pre_rst_full_i_ready", 32'(i_ready_o), 32'd0);
    reset     = 1'b1;
    e_ready_i = 1'b1;
    tick();
    chk("mid_rst_e_valid", 32'(e_valid_o), 32'd0);
    chk("mid_rst_e_data",  32'(e_data_o),  32'd0);
    chk("mid_rst_i_ready", 32'(i_ready_o), 32'd1);
    reset     = 1'b0;
    e_ready_i = 1'b0;
    i_data_i  = 8'hA5;
    tick();
    chk("a5_e_valid", 32'(e_valid_o), 32'd1);
    chk("a5_e_data",  32'(e_data_o),  32'hA5);
    i_valid_i = 1'b0;
    e_ready_i = 1'b1;
    tick();
    chk("a5_alone_e_valid", 32'(e_valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
